dds_wave_gen: RTL

Numerically controlled waveform source that produces the 14-bit offset-binary sample stream for the DAC output stage. The DAC output stage registers the sample onto the DAC bus and drives DA_CLK/DA_WR. The block holds a phase accumulator with a frequency tuning word and a phase offset. It generates sawtooth, triangle, square or quarter-wave-LUT sine samples, applies amplitude scaling, and delivers one sample per clock through a fixed-latency pipeline. Configuration is written into shadow registers and committed atomically by an update strobe.

---
 rtl/dds_wave_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dds_wave_gen.sv
// Phase-accumulator waveform source (saw / triangle / square / quarter-wave sine)
// with amplitude scaling and an offset-binary output through a fixed 4-clock pipeline.
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 14,
    parameter int LUT_AW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [PHASE_W-1:0] cfg_wdata,
    input  logic               update,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid
);

    localparam int                AMP_W    = 9;
    localparam logic [AMP_W-1:0]  AMP_FULL = 9'd256;
    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam int                LUT_N    = 2 ** LUT_AW;
    localparam real               PI       = 3.14159265358979323846;
    localparam real               LUT_PEAK = real'(2 ** (DATA_W - 1) - 1);

    typedef enum logic [1:0] {
        WAVE_SAW  = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SQR  = 2'd2,
        WAVE_SINE = 2'd3
    } wave_e;

    function automatic logic [AMP_W-1:0] amp_sat(input logic [AMP_W-1:0] raw);
        logic [AMP_W-1:0] res;
        if (raw > AMP_FULL) begin
            res = AMP_FULL;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // shadow and active configuration
    logic [PHASE_W-1:0] ftw_sh_r, pow_sh_r, ftw_r, pow_r;
    wave_e              wave_sh_r, wave_r;
    logic               en_sh_r, clr_sh_r, en_r;
    logic [AMP_W-1:0]   amp_sh_r, amp_r;

    logic [PHASE_W-1:0] ftw_nx_s, pow_nx_s;
    wave_e              wave_nx_s;
    logic               en_nx_s, clr_nx_s, clr_commit_s;
    logic [AMP_W-1:0]   amp_nx_s;

    // datapath: wave, amplitude and enable ride alongside each sample
    logic [PHASE_W-1:0] acc_r, ph_sum_s;
    logic [DATA_W:0]    ph_r;
    wave_e              wave1_r;
    logic [AMP_W-1:0]   amp1_r, amp2_r;
    logic               en1_r, en2_r, en3_r;
    logic [DATA_W-1:0]  s2_r, y3_r, dout_r;
    logic [3:0]         vld_sr_r;

    logic [DATA_W-1:0]           u_s, s_s;
    logic [LUT_AW-1:0]           lut_addr_s;
    logic [DATA_W-2:0]           lut_val_s;
    logic signed [DATA_W+AMP_W:0] prod_s;
    logic                        unused_s;

    // Quarter-wave table, sampled at bin centres so the folded quadrants meet without a repeated entry.
    logic [DATA_W-2:0] lut_s [LUT_N];
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        localparam int LUT_VAL = $rtoi(LUT_PEAK * $sin(PI / 2.0 * (gi + 0.5) / real'(LUT_N)) + 0.5);
        assign lut_s[gi] = LUT_VAL[DATA_W-2:0];
    end

    // Next shadow values; a write on the commit edge is forwarded into the active set.
    always_comb begin
        ftw_nx_s  = ftw_sh_r;
        pow_nx_s  = pow_sh_r;
        wave_nx_s = wave_sh_r;
        en_nx_s   = en_sh_r;
        clr_nx_s  = clr_sh_r;
        amp_nx_s  = amp_sh_r;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: ftw_nx_s = cfg_wdata;
                2'd1: pow_nx_s = cfg_wdata;
                2'd2: begin
                    wave_nx_s = wave_e'(cfg_wdata[1:0]);
                    en_nx_s   = cfg_wdata[2];
                    clr_nx_s  = cfg_wdata[3];
                end
                2'd3:    amp_nx_s = amp_sat(cfg_wdata[AMP_W-1:0]);
                default: ftw_nx_s = ftw_sh_r;
            endcase
        end else begin
            ftw_nx_s = ftw_sh_r;
        end
        clr_commit_s = update & clr_nx_s;
    end

    // Shadow register file and atomic commit into the active set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ftw_sh_r  <= {PHASE_W{1'b0}};
            pow_sh_r  <= {PHASE_W{1'b0}};
            wave_sh_r <= WAVE_SAW;
            en_sh_r   <= 1'b0;
            clr_sh_r  <= 1'b0;
            amp_sh_r  <= AMP_FULL;
            ftw_r     <= {PHASE_W{1'b0}};
            pow_r     <= {PHASE_W{1'b0}};
            wave_r    <= WAVE_SAW;
            en_r      <= 1'b0;
            amp_r     <= AMP_FULL;
        end else begin
            ftw_sh_r  <= ftw_nx_s;
            pow_sh_r  <= pow_nx_s;
            wave_sh_r <= wave_nx_s;
            en_sh_r   <= en_nx_s;
            clr_sh_r  <= update ? 1'b0 : clr_nx_s;
            amp_sh_r  <= amp_nx_s;
            if (update) begin
                ftw_r  <= ftw_nx_s;
                pow_r  <= pow_nx_s;
                wave_r <= wave_nx_s;
                en_r   <= en_nx_s;
                amp_r  <= amp_nx_s;
            end
        end
    end

    // Phase offset, waveform shaping and amplitude product.
    always_comb begin
        ph_sum_s   = acc_r + pow_r;
        lut_addr_s = ph_r[DATA_W-1] ? ~ph_r[DATA_W-2 -: LUT_AW] : ph_r[DATA_W-2 -: LUT_AW];
        lut_val_s  = lut_s[lut_addr_s];
        u_s        = MID;
        s_s        = {DATA_W{1'b0}};
        case (wave1_r)
            WAVE_SAW: u_s = ph_r[DATA_W:1];
            WAVE_TRI: u_s = ph_r[DATA_W] ? ~ph_r[DATA_W-1:0] : ph_r[DATA_W-1:0];
            WAVE_SQR: u_s = ph_r[DATA_W] ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
            default:  u_s = MID;
        endcase
        if (wave1_r == WAVE_SINE) begin
            s_s = ph_r[DATA_W] ? ({DATA_W{1'b0}} - {1'b0, lut_val_s}) : {1'b0, lut_val_s};
        end else begin
            s_s = u_s - MID;
        end
        prod_s   = $signed(s2_r) * $signed({1'b0, amp2_r});
        unused_s = ^{ph_sum_s[PHASE_W-DATA_W-2:0], prod_s[DATA_W+AMP_W:DATA_W+AMP_W-1],
                     prod_s[AMP_W-2:0]};
    end

    // Accumulator and the four sample stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= {PHASE_W{1'b0}};
            ph_r     <= {(DATA_W+1){1'b0}};
            wave1_r  <= WAVE_SAW;
            amp1_r   <= AMP_FULL;
            amp2_r   <= AMP_FULL;
            en1_r    <= 1'b0;
            en2_r    <= 1'b0;
            en3_r    <= 1'b0;
            s2_r     <= {DATA_W{1'b0}};
            y3_r     <= {DATA_W{1'b0}};
            dout_r   <= MID;
            vld_sr_r <= 4'b0000;
        end else begin
            if (clr_commit_s) begin
                acc_r <= {PHASE_W{1'b0}};
            end else if (en_r) begin
                acc_r <= acc_r + ftw_r;
            end
            ph_r     <= ph_sum_s[PHASE_W-1 -: DATA_W+1];
            wave1_r  <= wave_r;
            amp1_r   <= amp_r;
            en1_r    <= en_r;
            s2_r     <= s_s;
            amp2_r   <= amp1_r;
            en2_r    <= en1_r;
            y3_r     <= prod_s[DATA_W+AMP_W-2:AMP_W-1];
            en3_r    <= en2_r;
            dout_r   <= en3_r ? (y3_r + MID) : MID;
            vld_sr_r <= {vld_sr_r[2:0], 1'b1};
        end
    end

    assign dout       = dout_r;
    assign dout_valid = vld_sr_r[3];

endmodule
